// File: rtl/qdr_arb_pkg.sv
// Shared types and helpers for the QDR-II+ client arbiter.
// clidx_t is sized for the default client count; modules derive their own index width.
package qdr_arb_pkg;

    localparam int unsigned NUM_CLIENTS_DFLT = 4;
    localparam int unsigned ADDR_BITS_DFLT   = 18;
    localparam int unsigned DATA_WIDTH_DFLT  = 144;
    localparam int unsigned TAG_DEPTH_DFLT   = 16;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CLIDX_W = idx_width(NUM_CLIENTS_DFLT);

    typedef logic [CLIDX_W-1:0] clidx_t;

    // Classification of a controller read return.
    typedef enum logic [1:0] {
        RetNone,
        RetRoute,
        RetUnderflow
    } ret_kind_e;

endpackage

// File: rtl/qdr_client_arbiter_if.sv
// Client-side and controller-side bus of the QDR client arbiter.
// slave is the arbiter view; master is the client/controller (testbench) view.
interface qdr_client_arbiter_if
    import qdr_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DFLT,
    parameter int unsigned ADDR_BITS   = ADDR_BITS_DFLT,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DFLT,
    parameter int unsigned TAG_DEPTH   = TAG_DEPTH_DFLT
);

    localparam int unsigned IdxW = idx_width(NUM_CLIENTS);
    localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

    logic [NUM_CLIENTS-1:0]                 cl_wr_en;
    logic [NUM_CLIENTS-1:0][ADDR_BITS-1:0]  cl_wr_addr;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] cl_wr_data;
    logic [NUM_CLIENTS-1:0]                 cl_wr_ready;
    logic [NUM_CLIENTS-1:0]                 cl_rd_en;
    logic [NUM_CLIENTS-1:0][ADDR_BITS-1:0]  cl_rd_addr;
    logic [NUM_CLIENTS-1:0]                 cl_rd_ready;
    logic [NUM_CLIENTS-1:0]                 cl_rd_valid;
    logic [DATA_WIDTH-1:0]                  cl_rd_data;
    logic                                   lock_en;
    logic [IdxW-1:0]                        lock_sel;
    logic                                   ram_wr_en;
    logic [ADDR_BITS-1:0]                   ram_wr_addr;
    logic [DATA_WIDTH-1:0]                  ram_wr_data;
    logic                                   ram_rd_en;
    logic [ADDR_BITS-1:0]                   ram_rd_addr;
    logic                                   ram_rd_valid;
    logic [DATA_WIDTH-1:0]                  ram_rd_data;
    logic [CntW-1:0]                        rd_outstanding;
    logic                                   err_rd_underflow;

    modport slave (
        input  cl_wr_en, cl_wr_addr, cl_wr_data,
        output cl_wr_ready,
        input  cl_rd_en, cl_rd_addr,
        output cl_rd_ready, cl_rd_valid, cl_rd_data,
        input  lock_en, lock_sel,
        output ram_wr_en, ram_wr_addr, ram_wr_data,
        output ram_rd_en, ram_rd_addr,
        input  ram_rd_valid, ram_rd_data,
        output rd_outstanding, err_rd_underflow
    );

    modport master (
        output cl_wr_en, cl_wr_addr, cl_wr_data,
        input  cl_wr_ready,
        output cl_rd_en, cl_rd_addr,
        input  cl_rd_ready, cl_rd_valid, cl_rd_data,
        output lock_en, lock_sel,
        input  ram_wr_en, ram_wr_addr, ram_wr_data,
        input  ram_rd_en, ram_rd_addr,
        output ram_rd_valid, ram_rd_data,
        input  rd_outstanding, err_rd_underflow
    );

endinterface

// File: rtl/qdr_rr_arbiter.sv
// Round-robin arbiter with exclusive lock: one-hot grant plus its pointer register.
// The pointer moves past the winner only on unlocked grants.
module qdr_rr_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DFLT,
    parameter int unsigned IdxW        = idx_width(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic                   lock_en_i,
    input  logic [IdxW-1:0]        lock_sel_i,
    output logic [NUM_CLIENTS-1:0] gnt_o,
    output logic                   gnt_valid_o,
    output logic [IdxW-1:0]        gnt_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    int unsigned     cand;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = 0;
        if (lock_en_i) begin
            if ((32'(lock_sel_i) < NUM_CLIENTS) && req_i[lock_sel_i]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = lock_sel_i;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
                cand = (32'(ptr_q) + k) % NUM_CLIENTS;
                if (!gnt_valid_o && req_i[cand]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = IdxW'(cand);
                end
            end
        end
        gnt_o = '0;
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o && !lock_en_i) begin
            ptr_d = (gnt_idx_o == IdxW'(NUM_CLIENTS - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    gnt_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));

endmodule

// File: rtl/qdr_client_arbiter.sv
// N-client arbiter onto one QDR-II+ controller command port: independent read/write
// round-robin, MBIST lock, and in-order read-return routing through a tag FIFO.
module qdr_client_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DFLT,
    parameter int unsigned ADDR_BITS   = ADDR_BITS_DFLT,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DFLT,
    parameter int unsigned TAG_DEPTH   = TAG_DEPTH_DFLT
) (
    input logic                  clk,
    input logic                  rst_n,
    qdr_client_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = idx_width(NUM_CLIENTS);
    localparam int unsigned PtrW = idx_width(TAG_DEPTH);
    localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

    logic [NUM_CLIENTS-1:0] wr_gnt, rd_gnt, rd_req;
    logic                   wr_gnt_valid, rd_gnt_valid;
    logic [IdxW-1:0]        wr_gnt_idx, rd_gnt_idx;

    logic [IdxW-1:0] tag_mem_q [TAG_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rd_full, rd_empty, push, pop;
    ret_kind_e       ret_kind;

    logic                   ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_BITS-1:0]   ram_wr_addr_q, ram_wr_addr_d;
    logic [DATA_WIDTH-1:0]  ram_wr_data_q, ram_wr_data_d;
    logic                   ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_BITS-1:0]   ram_rd_addr_q, ram_rd_addr_d;
    logic [NUM_CLIENTS-1:0] cl_rd_valid_q, cl_rd_valid_d;
    logic [DATA_WIDTH-1:0]  cl_rd_data_q, cl_rd_data_d;
    logic                   err_q, err_d;

    assign rd_full  = (cnt_q == CntW'(TAG_DEPTH));
    assign rd_empty = (cnt_q == '0);
    // A full tag FIFO blocks reads outright, even if a return pops this cycle.
    assign rd_req   = bus.cl_rd_en & {NUM_CLIENTS{~rd_full}};

    qdr_rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IdxW        (IdxW)
    ) u_wr_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (bus.cl_wr_en),
        .lock_en_i   (bus.lock_en),
        .lock_sel_i  (bus.lock_sel),
        .gnt_o       (wr_gnt),
        .gnt_valid_o (wr_gnt_valid),
        .gnt_idx_o   (wr_gnt_idx)
    );

    qdr_rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IdxW        (IdxW)
    ) u_rd_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (rd_req),
        .lock_en_i   (bus.lock_en),
        .lock_sel_i  (bus.lock_sel),
        .gnt_o       (rd_gnt),
        .gnt_valid_o (rd_gnt_valid),
        .gnt_idx_o   (rd_gnt_idx)
    );

    always_comb begin
        ret_kind = RetNone;
        if (bus.ram_rd_valid) begin
            ret_kind = rd_empty ? RetUnderflow : RetRoute;
        end
    end

    assign push = rd_gnt_valid;
    assign pop  = (ret_kind == RetRoute);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Tag storage holds only client indices; emptiness is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wptr_q] <= rd_gnt_idx;
        end
    end

    always_comb begin
        ram_wr_en_d   = wr_gnt_valid;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        if (wr_gnt_valid) begin
            ram_wr_addr_d = bus.cl_wr_addr[wr_gnt_idx];
            ram_wr_data_d = bus.cl_wr_data[wr_gnt_idx];
        end
        ram_rd_en_d   = rd_gnt_valid;
        ram_rd_addr_d = ram_rd_addr_q;
        if (rd_gnt_valid) begin
            ram_rd_addr_d = bus.cl_rd_addr[rd_gnt_idx];
        end
        cl_rd_valid_d = '0;
        cl_rd_data_d  = cl_rd_data_q;
        err_d         = err_q;
        unique case (ret_kind)
            RetRoute: begin
                cl_rd_valid_d[tag_mem_q[rptr_q]] = 1'b1;
                cl_rd_data_d = bus.ram_rd_data;
            end
            RetUnderflow: err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
            cl_rd_valid_q <= '0;
            cl_rd_data_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cnt_q         <= cnt_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            cl_rd_valid_q <= cl_rd_valid_d;
            cl_rd_data_q  <= cl_rd_data_d;
            err_q         <= err_d;
        end
    end

    assign bus.cl_wr_ready      = wr_gnt;
    assign bus.cl_rd_ready      = rd_gnt;
    assign bus.cl_rd_valid      = cl_rd_valid_q;
    assign bus.cl_rd_data       = cl_rd_data_q;
    assign bus.ram_wr_en        = ram_wr_en_q;
    assign bus.ram_wr_addr      = ram_wr_addr_q;
    assign bus.ram_wr_data      = ram_wr_data_q;
    assign bus.ram_rd_en        = ram_rd_en_q;
    assign bus.ram_rd_addr      = ram_rd_addr_q;
    assign bus.rd_outstanding   = cnt_q;
    assign bus.err_rd_underflow = err_q;

endmodule
